// File: rtl/popcount_index_stream_pkg.sv
// Shared types and default widths for the popcount index streamer.
// Defaults are derived from the vector width so the three stay consistent.
package popcount_index_stream_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  // Ceiling log2 usable in parameter expressions.
  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result++;
      rem = rem >> 1;
    end
    return result;
  endfunction

  localparam int DEF_IN_SIZE  = 16;
  localparam int DEF_OUT_SIZE = clog2(DEF_IN_SIZE + 1);
  localparam int DEF_IDX_SIZE = clog2(DEF_IN_SIZE);

endpackage

// File: rtl/popcount_index_stream_lsb_priority_encoder.sv
// Combinational lowest-set-bit finder; also returns the vector with that bit
// removed and whether at most one bit is set.
module lsb_priority_encoder
  import popcount_index_stream_pkg::*;
#(
  parameter int IN_SIZE  = DEF_IN_SIZE,
  parameter int IDX_SIZE = DEF_IDX_SIZE
) (
  input  logic [IN_SIZE-1:0]  vec,
  output logic [IDX_SIZE-1:0] idx,
  output logic                any,
  output logic                single,
  output logic [IN_SIZE-1:0]  cleared
);

  // Scanning from the top lets the lowest set bit win the last assignment.
  always_comb begin
    // NOTE: a default before the loop keeps this purely combinational (no latch).
    idx = '0;
    for (int i = IN_SIZE - 1; i >= 0; i--) begin
      if (vec[i]) idx = IDX_SIZE'(i);
    end
  end

  assign cleared = vec & (vec - IN_SIZE'(1));
  assign any     = |vec;
  assign single  = ~|cleared;

endmodule

// File: rtl/popcount_index_stream.sv
// Expands a captured vector into a handshake stream of set-bit indices,
// lowest first, each beat tagged with its 1-based ordinal.
module popcount_index_stream
  import popcount_index_stream_pkg::*;
#(
  parameter int IN_SIZE  = DEF_IN_SIZE,
  parameter int OUT_SIZE = DEF_OUT_SIZE,
  parameter int IDX_SIZE = DEF_IDX_SIZE
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [IN_SIZE-1:0]  A,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [IDX_SIZE-1:0] out_index,
  output logic                out_last,
  output logic                out_empty,
  output logic [OUT_SIZE-1:0] count
);

  state_t                state_q, state_d;
  logic [IN_SIZE-1:0]    shadow_q, shadow_d;
  logic [OUT_SIZE-1:0]   ordinal_q, ordinal_d;

  logic [IDX_SIZE-1:0]   lsb_idx;
  logic                  lsb_any;
  logic                  lsb_single;
  logic [IN_SIZE-1:0]    lsb_cleared;

  lsb_priority_encoder #(
    .IN_SIZE  (IN_SIZE),
    .IDX_SIZE (IDX_SIZE)
  ) u_lsb_enc (
    .vec     (shadow_q),
    .idx     (lsb_idx),
    .any     (lsb_any),
    .single  (lsb_single),
    .cleared (lsb_cleared)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      shadow_q  <= '0;
      ordinal_q <= '0;
    end else begin
      // NOTE: non-blocking updates so every register samples pre-edge values.
      state_q   <= state_d;
      shadow_q  <= shadow_d;
      ordinal_q <= ordinal_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    shadow_d  = shadow_q;
    ordinal_d = ordinal_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          shadow_d  = A;
          ordinal_d = OUT_SIZE'(1);
          state_d   = EMIT;
        end
      end
      EMIT: begin
        if (out_ready) begin
          // A zero vector also reports single, so its lone beat ends the stream.
          if (lsb_single) begin
            shadow_d  = '0;
            ordinal_d = '0;
            state_d   = IDLE;
          end else begin
            shadow_d  = lsb_cleared;
            ordinal_d = ordinal_q + OUT_SIZE'(1);
          end
        end
      end
    endcase
  end

  // Outputs decode from registered state, so reset clears them asynchronously.
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = 1'b0;
    out_index = '0;
    out_last  = 1'b0;
    out_empty = 1'b0;
    count     = '0;
    if (state_q == EMIT) begin
      out_valid = 1'b1;
      out_index = lsb_idx;
      out_last  = lsb_single;
      out_empty = !lsb_any;
      count     = lsb_any ? ordinal_q : '0;
    end
  end

endmodule

// File: tb/tb_popcount_index_stream.sv
// Scoreboard bench: the driver queues expected beats from a set-bit model,
// a negedge monitor pops and compares every accepted beat.
module tb_popcount_index_stream;

  localparam int IN_SIZE  = 16;
  localparam int OUT_SIZE = 5;
  localparam int IDX_SIZE = 4;

  typedef struct {
    int idx;
    int cnt;
    bit last;
    bit empty;
  } beat_t;

  logic                clk;
  logic                rst_n;
  logic                in_valid;
  logic                in_ready;
  logic [IN_SIZE-1:0]  A;
  logic                out_valid;
  logic                out_ready;
  logic [IDX_SIZE-1:0] out_index;
  logic                out_last;
  logic                out_empty;
  logic [OUT_SIZE-1:0] count;

  int    tests = 0;
  int    fails = 0;
  int    acc_cnt = 0;
  int    ready_mode = 0;
  beat_t exp_q[$];

  popcount_index_stream #(
    .IN_SIZE  (IN_SIZE),
    .OUT_SIZE (OUT_SIZE),
    .IDX_SIZE (IDX_SIZE)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_index (out_index),
    .out_last  (out_last),
    .out_empty (out_empty),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: enumerate set bits in ascending order.
  task automatic push_expected(input logic [IN_SIZE-1:0] v);
    int n;
    int k;
    beat_t b;
    n = $countones(v);
    if (n == 0) begin
      b.idx = 0; b.cnt = 0; b.last = 1'b1; b.empty = 1'b1;
      exp_q.push_back(b);
    end else begin
      k = 0;
      for (int i = 0; i < IN_SIZE; i++) begin
        if (v[i]) begin
          k++;
          b.idx = i; b.cnt = k; b.last = (k == n); b.empty = 1'b0;
          exp_q.push_back(b);
        end
      end
    end
  endtask

  // out_ready is updated just after each rising edge.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ~out_ready;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: compares accepted beats, stall stability and back-to-back validity.
  initial begin
    logic                prev_stall = 1'b0;
    logic                prev_cont  = 1'b0;
    logic [IDX_SIZE-1:0] h_idx = '0;
    logic [OUT_SIZE-1:0] h_cnt = '0;
    logic                h_last = 1'b0;
    logic                h_empty = 1'b0;
    beat_t               b;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 1'b0;
        prev_cont  = 1'b0;
        continue;
      end
      check("in_ready_vs_valid", 32'(in_ready), 32'(!out_valid));
      if (prev_stall) begin
        check("stall_valid", 32'(out_valid), 32'd1);
        check("stall_index", 32'(out_index), 32'(h_idx));
        check("stall_count", 32'(count), 32'(h_cnt));
        check("stall_last", 32'(out_last), 32'(h_last));
        check("stall_empty", 32'(out_empty), 32'(h_empty));
      end
      if (prev_cont) check("next_beat_valid", 32'(out_valid), 32'd1);
      prev_stall = out_valid && !out_ready;
      prev_cont  = 1'b0;
      h_idx = out_index; h_cnt = count; h_last = out_last; h_empty = out_empty;
      if (out_valid && out_ready) begin
        acc_cnt++;
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_beat: index %0d count %0d with no beat expected", out_index, count);
        end else begin
          b = exp_q.pop_front();
          check("beat_index", 32'(out_index), 32'(b.idx));
          check("beat_count", 32'(count), 32'(b.cnt));
          check("beat_last", 32'(out_last), 32'(b.last));
          check("beat_empty", 32'(out_empty), 32'(b.empty));
          prev_cont = !b.last;
        end
      end
    end
  end

  task automatic send(input logic [IN_SIZE-1:0] v);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!in_ready && n < 200);
    check("send_in_ready_timeout", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    A        = v;
    push_expected(v);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    A        = IN_SIZE'($urandom);
    check("first_beat_latency", 32'(out_valid), 32'd1);
    check("busy_in_ready", 32'(in_ready), 32'd0);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 500) begin
      @(posedge clk);
      n++;
    end
    check("drain_timeout", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
  endtask

  initial begin
    int base;
    int n;
    logic [IN_SIZE-1:0] v;

    rst_n    = 1'b0;
    in_valid = 1'b0;
    A        = '0;
    #12;
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_count", 32'(count), 32'd0);
    check("reset_index", 32'(out_index), 32'd0);
    check("reset_last", 32'(out_last), 32'd0);
    check("reset_empty", 32'(out_empty), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    send(16'h0001); drain();
    send(16'h0003); drain();
    send(16'h0080); drain();
    send(16'h007F); drain();
    ready_mode = 1;
    send(16'hFFFF); drain();
    ready_mode = 0;
    send(16'h0000); drain();

    // Reset in the middle of a stream discards it.
    base = acc_cnt;
    send(16'h8421);
    n = 0;
    while (acc_cnt < base + 2 && n < 100) begin
      @(posedge clk);
      n++;
    end
    check("mid_reset_accepts", 32'(acc_cnt - base), 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_reset_out_valid", 32'(out_valid), 32'd0);
    check("mid_reset_in_ready", 32'(in_ready), 32'd1);
    check("mid_reset_count", 32'(count), 32'd0);
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    send(16'h0002); drain();

    ready_mode = 2;
    for (int t = 0; t < 40; t++) begin
      case ($urandom_range(0, 3))
        0:       v = '0;
        1:       v = IN_SIZE'($urandom) & IN_SIZE'($urandom) & IN_SIZE'($urandom);
        default: v = IN_SIZE'($urandom);
      endcase
      send(v);
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/popcount_index_stream.md
Name: popcount_index_stream

Overview:
Sequential companion to the combinational popcount tree, running in the other direction. The popcount tree reduces a vector to a count. This block expands a captured vector into a stream of set-bit indices: one index per handshake beat, lowest index first. Each beat carries its running ordinal, so the last beat's count equals the popcount. It sits between a vector producer, such as a mask or sparse-activation register, and index consumers, such as address generators or sparse MAC schedulers.

Parameters:
IN_SIZE, 16, width of the input vector A.
OUT_SIZE, 5, width of count; must be >= clog2(IN_SIZE+1).
IDX_SIZE, 4, width of out_index; must be >= clog2(IN_SIZE).

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  asynchronous, active-low reset.
in_valid  input  1  A is valid.
in_ready  output  1  block can accept a vector.
A  input  IN_SIZE  vector to enumerate.
out_valid  output  1  output beat valid.
out_ready  input  1  consumer accepts the beat.
out_index  output  IDX_SIZE  bit position of the current set bit.
out_last  output  1  final beat for this vector.
out_empty  output  1  the captured vector was all zeros.
count  output  OUT_SIZE  1-based ordinal of the current beat; equals the popcount on the last beat.

Behaviour:
- Clocking and reset:
  - Single clock, clk.
  - rst_n is asynchronous and active-low; release is synchronous to clk.
  - Reset values: state=IDLE; shadow vector=0; ordinal=0; out_valid=0, out_last=0, out_empty=0, out_index=0, count=0.
  - in_ready=1 while in reset and immediately after it.
- States are IDLE and EMIT.
- IDLE:
  - in_ready=1 and out_valid=0.
  - On in_valid at a clock edge, capture A into the shadow register, set ordinal=1 and go to EMIT.
- EMIT:
  - in_ready=0 and out_valid=1.
  - out_index = position of the lowest set bit of the shadow register.
  - count = ordinal.
  - out_last=1 when the shadow register has at most one bit set.
- Zero vector: if the captured A==0, EMIT presents a single beat with out_empty=1, out_last=1, out_index=0 and count=0.
- Accept (out_valid && out_ready):
  - Clear the lowest set bit in the shadow register and increment ordinal.
  - If out_last, return to IDLE and clear the shadow register.
- Stall (out_ready=0): out_index, out_last, out_empty and count hold stable; out_valid stays 1.
- Latency: the first beat is valid in the cycle after capture.
- Throughput: one index per cycle under continuous out_ready.
- Bubble: one idle cycle between vectors, because in_ready is high only in IDLE.
- in_valid is ignored while in EMIT; A is sampled only at capture.
- Ordinal never wraps: at most IN_SIZE beats per vector, and OUT_SIZE is wide enough for IN_SIZE.
- Reset asserted mid-stream: the vector is discarded, out_valid drops asynchronously, and the block returns to IDLE.
- All ones (A = all ones): IN_SIZE beats with indices 0..IN_SIZE-1; the last beat has count=IN_SIZE.

Decomposition:
- Shared package:
  - state enum {IDLE, EMIT};
  - clog2 constant function;
  - default width constants IN_SIZE=16, OUT_SIZE=5, IDX_SIZE=4.
- Sub-module lsb_priority_encoder:
  - purely combinational;
  - input vec[IN_SIZE];
  - outputs idx[IDX_SIZE], any and single (at most one bit set);
  - also produces the lowest-bit-cleared vector, vec & (vec-1).

Test Plan:
- Reset, then A=16'h0001 with in_valid for one cycle and out_ready=1: one beat with index=0, count=1, last=1, empty=0; in_ready high again the next cycle.
- A=16'h0003 with out_ready held 1: beats (0,1,last=0) then (1,2,last=1) on consecutive cycles.
- A=16'h0080, then A=16'h007F: beat (7,1,last); after the bubble, indices 0..6 with count 1..7, last on count=7.
- A=16'hFFFF with out_ready toggling 1,0,1,0: 16 beats, indices 0..15 held stable across stalls, final count=16 with last=1.
- A=16'h0000: single beat with empty=1, last=1, count=0, index=0.
- A=16'h8421, reset pulsed after the second accepted beat: out_valid=0 immediately and in_ready=1; a subsequent A=16'h0002 yields one beat (1,1,last).
